bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 DIGITS, 4, number of packed BCD digits per operand (legal range 1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*DIGITS  operand B, packed BCD, same packing as a.
REQ-007 c_in  input  1  carry into digit 0.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  single-cycle pulse when sum/c_out become valid.
REQ-010 sum  output  4*DIGITS  packed BCD result.
REQ-011 c_out  output  1  decimal carry out of the most significant digit.
REQ-012 err  output  1  at least one operand digit was greater than 9.

Function
REQ-013 FSM states SHALL be IDLE, ADD and DONE.
- IDLE->ADD on start=1.
- ADD->DONE after the digit DIGITS-1 cycle.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On start in IDLE, the block SHALL latch a, b and c_in, clear the digit index to 0, clear the internal sum register and clear err.
REQ-015 In ADD, the block SHALL process one digit per cycle, least significant first; the index increments by 1 each cycle.
REQ-016 Digit rule: raw = a_d + b_d + carry (5 bits).
- If raw > 9: digit = (raw + 6) mod 16, carry = 1.
- Otherwise: digit = raw, carry = 0.
REQ-017 The carry register SHALL initialise from the latched c_in and update every ADD cycle.
REQ-018 Each result digit SHALL be written into its slot of the internal sum register in the cycle it is computed.
REQ-019 err SHALL be set in any ADD cycle where a_d > 9 or b_d > 9, and remain set until the next accepted start or reset.
- The computation completes normally using the REQ-016 rule.
REQ-020 Latency: start sampled at edge T -> done high during the cycle after edge T+DIGITS; busy high from T+1 through the DONE cycle inclusive.
REQ-021 sum and c_out SHALL update only on entry to DONE, and hold until the next DONE.
- Intermediate digits SHALL NOT be visible on sum.
REQ-022 start asserted while busy=1 SHALL be ignored, with no queuing.
- start asserted in the DONE cycle SHALL also be ignored.
REQ-023 Input changes on a, b and c_in after the latching edge SHALL NOT affect the result in progress.
REQ-024 With DIGITS=1, ADD SHALL last exactly one cycle.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL enter IDLE.
- busy=0, done=0, sum=0, c_out=0, err=0.
- Index and carry registers cleared.
REQ-026 Reset asserted mid-ADD SHALL abort the computation; no done pulse is produced for it.
REQ-027 start is accepted on the first edge after rst_n returns high.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the BCD_MAX constant (9) and the BCD_CORR constant (6).
REQ-029 The digit rule SHALL be implemented in one combinational sub-module, bcd_digit_add.
- Ports: a, b, c_in, sum, c_out.
- Instantiated once and time-multiplexed across digits.

Verification
REQ-030 Scenario 1: a=0003, b=0001, c_in=0, start pulse -> done after 5 cycles; sum=0004, c_out=0, err=0.
REQ-031 Scenario 2: a=0008, b=0005 -> sum=0013, c_out=0; then a=0009, b=0008 -> sum=0017.
REQ-032 Scenario 3: a=9999, b=0001, c_in=0 -> sum=0000, c_out=1; and a=0000, b=0000, c_in=1 -> sum=0001, c_out=0.
REQ-033 Scenario 4: a=000A, b=0001 -> err=1 with done; sum digit 0 = 1 (raw 11 -> corrected), carry propagated; err clears on next valid start.
REQ-034 Scenario 5: start at cycle 0, a second start at cycles 2 and 5 with different operands -> exactly one done, carrying the first result; busy never drops early.
REQ-035 Scenario 6: rst_n=0 at cycle 2 of ADD -> no done pulse, all outputs 0 next cycle; a new start then completes correctly.

Source files
------------

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding and BCD constants.
// The block and its digit cell both import this package.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic bcd_digit_invalid(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Single-digit BCD adder cell: binary add, then +6 correction when the raw sum exceeds 9.
// Purely combinational; the serial adder time-multiplexes one instance across all digits.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] w_raw;

    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
        sum   = w_raw[3:0];
        c_out = 1'b0;
        // Adding 6 skips the six unused codes; the 4-bit wrap drops the binary carry.
        if (w_raw > {1'b0, BCD_MAX}) begin
            sum   = w_raw[3:0] + BCD_CORR;
            c_out = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: latches operands on start and adds one digit per cycle,
// LSD first. The result appears on sum/c_out only on entry to DONE, with a one-cycle done pulse.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                c_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                c_out,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_err;

    logic [3:0]       w_aDigit;
    logic [3:0]       w_bDigit;
    logic [3:0]       w_digit;
    logic             w_carry;
    logic [W-1:0]     w_accNext;
    logic             w_accept;
    logic             w_lastDigit;
    logic             w_digitErr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = ADD;
                    w_accept    = 1'b1;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (w_lastDigit) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign w_aDigit    = r_a[r_idx*4 +: 4];
    assign w_bDigit    = r_b[r_idx*4 +: 4];
    assign w_lastDigit = (r_idx == LAST_IDX);
    assign w_digitErr  = bcd_digit_invalid(w_aDigit) || bcd_digit_invalid(w_bDigit);

    bcd_digit_add u_digitAdd (
        .a     (w_aDigit),
        .b     (w_bDigit),
        .c_in  (r_carry),
        .sum   (w_digit),
        .c_out (w_carry)
    );

    always_comb begin
        w_accNext                 = r_acc;
        w_accNext[r_idx*4 +: 4]   = w_digit;
    end

    // The last digit goes straight from the cell into r_sum so the result lands on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ADD) begin
            r_acc   <= w_accNext;
            r_carry <= w_carry;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_digitErr) begin
                r_err <= 1'b1;
            end
            if (w_lastDigit) begin
                r_sum  <= w_accNext;
                r_cout <= w_carry;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): hand-computed sums, latency, busy/done
// framing, error flag, ignored starts and mid-computation reset.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] lastSum;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .err   (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; start is sampled on the next rising edge.
    task automatic applyStimulus(input string tag, input logic [15:0] opA, input logic [15:0] opB,
                                 input logic cin, input logic [15:0] expSum,
                                 input logic expCout, input logic expErr);
        int cnt;
        a     = opA;
        b     = opB;
        c_in  = cin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'h7777;
        b     = 16'h2222;
        c_in  = ~cin;
        cnt   = 1;
        checkOutput({tag, "_busy_first"}, 32'(busy), 32'd1);
        while (!done && cnt < 20) begin
            checkOutput({tag, "_sum_hidden"}, 32'(sum), 32'(lastSum));
            checkOutput({tag, "_busy_add"}, 32'(busy), 32'd1);
            @(negedge clk);
            cnt++;
        end
        checkOutput({tag, "_latency"}, 32'(cnt), 32'd5);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(c_out), 32'(expCout));
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd1);
        lastSum = expSum;
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_sum_hold"}, 32'(sum), 32'(expSum));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCount;
        int doneAt;
        int busyLow;
        int busyHigh;

        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        c_in    = 1'b0;
        lastSum = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(c_out), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);

        // Start on the very first edge after reset release.
        rst_n = 1'b1;
        applyStimulus("s1", 16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b0);
        applyStimulus("s2a", 16'h0008, 16'h0005, 1'b0, 16'h0013, 1'b0, 1'b0);
        applyStimulus("s2b", 16'h0009, 16'h0008, 1'b0, 16'h0017, 1'b0, 1'b0);
        applyStimulus("s3a", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus("s3b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus("mix", 16'h4567, 16'h5678, 1'b1, 16'h0246, 1'b1, 1'b0);
        applyStimulus("s4err", 16'h000A, 16'h0001, 1'b0, 16'h0011, 1'b0, 1'b1);
        applyStimulus("s4clr", 16'h0008, 16'h0005, 1'b0, 16'h0013, 1'b0, 1'b0);

        // Extra starts during ADD and in the DONE cycle must be dropped.
        a         = 16'h1234;
        b         = 16'h1111;
        c_in      = 1'b0;
        start     = 1'b1;
        doneCount = 0;
        doneAt    = 0;
        busyLow   = 0;
        busyHigh  = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                doneAt = k;
            end
            if (k <= 5 && !busy) busyLow++;
            if (k >= 6 && busy) busyHigh++;
            start = (k == 2 || k == 5);
            if (k == 2) begin
                a = 16'h5555;
                b = 16'h4444;
            end
        end
        checkOutput("s5_done_count", 32'(doneCount), 32'd1);
        checkOutput("s5_done_at", 32'(doneAt), 32'd5);
        checkOutput("s5_busy_early_drop", 32'(busyLow), 32'd0);
        checkOutput("s5_busy_requeued", 32'(busyHigh), 32'd0);
        checkOutput("s5_sum", 32'(sum), 32'h2345);
        checkOutput("s5_cout", 32'(c_out), 32'd0);
        lastSum = 16'h2345;

        // Reset two cycles into an erroring computation.
        a     = 16'h000A;
        b     = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("s6_err_mid", 32'(err), 32'd1);
        checkOutput("s6_busy_mid", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("s6_busy", 32'(busy), 32'd0);
        checkOutput("s6_done", 32'(done), 32'd0);
        checkOutput("s6_sum", 32'(sum), 32'd0);
        checkOutput("s6_cout", 32'(c_out), 32'd0);
        checkOutput("s6_err", 32'(err), 32'd0);
        lastSum = '0;
        rst_n   = 1'b1;
        applyStimulus("s6_after", 16'h0456, 16'h0544, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
